// File: rtl/opcode_issue.sv
// Instruction buffer that issues opcode/operand pairs toward the ALU decoder, halting on opcode 4'hF.
// Optional macro OPCODE_ISSUE_STALL_COUNT_EN adds a saturating stall_count output.
module opcode_issue #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         opcode,
   output logic [INSTR_W-5:0] operand,
   output logic               halted,
   output logic [7:0]         issued_count
`ifdef OPCODE_ISSUE_STALL_COUNT_EN
   ,
   output logic [7:0]         stall_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_HALT = 1'b1;

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [PTR_W:0]     wr_ptr, rd_ptr;
   logic [0:0]         state;
   logic               empty, full, push, pop;
   logic [INSTR_W-1:0] head;

   // The extra MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign head      = mem[rd_ptr[PTR_W-1:0]];
   assign in_ready  = !full;
   assign out_valid = !empty && (state == S_RUN);
   assign halted    = (state == S_HALT);
   assign opcode    = empty ? 4'h0 : head[INSTR_W-1 -: 4];
   assign operand   = empty ? '0 : head[INSTR_W-5:0];

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // NOTE: storage has no reset; the pointers define validity and the outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= in_instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         state        <= S_RUN;
         issued_count <= 8'd0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         state  <= S_RUN;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop) begin
            rd_ptr       <= rd_ptr + (PTR_W+1)'(1);
            issued_count <= issued_count + 8'd1;
            if (head[INSTR_W-1 -: 4] == 4'hF) state <= S_HALT;
         end
      end
   end

`ifdef OPCODE_ISSUE_STALL_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= 8'd0;
      else if (flush)
         stall_count <= 8'd0;
      else if (out_valid && !out_ready && (stall_count != 8'hFF))
         stall_count <= stall_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_opcode_issue.sv
// Self-checking bench for opcode_issue: a negedge scoreboard models buffer, state and counters,
// while scenario tasks check the directed corner cases.
module tb_opcode_issue;

   localparam int DEPTH   = 4;
   localparam int INSTR_W = 16;

   logic               clk;
   logic               rst_n;
   logic               flush;
   logic               in_valid;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         opcode;
   logic [INSTR_W-5:0] operand;
   logic               halted;
   logic [7:0]         issued_count;
`ifdef OPCODE_ISSUE_STALL_COUNT_EN
   logic [7:0]         stall_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [INSTR_W-1:0] sb_q[$];
   logic [7:0]         exp_count;
   logic               exp_halt;

   opcode_issue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_instr     (in_instr),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .opcode       (opcode),
      .operand      (operand),
      .halted       (halted),
      .issued_count (issued_count)
`ifdef OPCODE_ISSUE_STALL_COUNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compares DUT outputs to the model state, then applies what the coming edge will do.
   task automatic monitor_step();
      logic exp_valid, accept;
      logic [INSTR_W-1:0] h;
      if (!rst_n) begin
         sb_q.delete();
         exp_count = 8'd0;
         exp_halt  = 1'b0;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || halted !== 1'b0 || issued_count !== 8'd0) begin
            errors++;
            $display("FAIL mon_reset: got v=%b r=%b h=%b cnt=%0d, want v=0 r=1 h=0 cnt=0",
                     out_valid, in_ready, halted, issued_count);
         end
         return;
      end
      exp_valid = (sb_q.size() != 0) && !exp_halt;
      checks++;
      if (out_valid !== exp_valid || in_ready !== (sb_q.size() < DEPTH) ||
          halted !== exp_halt || issued_count !== exp_count) begin
         errors++;
         $display("FAIL mon_state: got v=%b r=%b h=%b cnt=%0d, want v=%b r=%b h=%b cnt=%0d",
                  out_valid, in_ready, halted, issued_count,
                  exp_valid, (sb_q.size() < DEPTH), exp_halt, exp_count);
      end
      if (exp_valid) begin
         checks++;
         if ({opcode, operand} !== sb_q[0]) begin
            errors++;
            $display("FAIL mon_head: got %h, want %h", {opcode, operand}, sb_q[0]);
         end
      end
      if (flush) begin
         sb_q.delete();
         exp_halt = 1'b0;
      end else begin
         accept = in_valid && (sb_q.size() < DEPTH);
         if (exp_valid && out_ready) begin
            h = sb_q.pop_front();
            exp_count++;
            if (h[INSTR_W-1 -: 4] == 4'hF) exp_halt = 1'b1;
         end
         if (accept) sb_q.push_back(in_instr);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0 ||
          opcode !== 4'h0 || operand !== 12'h0 || issued_count !== 8'd0) begin
         errors++;
         $display("FAIL reset: got r=%b v=%b h=%b op=%h opd=%h cnt=%0d, want 1 0 0 0 000 0",
                  in_ready, out_valid, halted, opcode, operand, issued_count);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 16'h1234;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || opcode !== 4'h1 || operand !== 12'h234) begin
         errors++;
         $display("FAIL single_latency: got v=%b op=%h opd=%h, want v=1 op=1 opd=234",
                  out_valid, opcode, operand);
      end
      repeat (2) step();
      checks++;
      if (out_valid !== 1'b1 || opcode !== 4'h1 || operand !== 12'h234) begin
         errors++;
         $display("FAIL single_hold: got v=%b op=%h opd=%h, want v=1 op=1 opd=234",
                  out_valid, opcode, operand);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || issued_count !== 8'd1) begin
         errors++;
         $display("FAIL single_issue: got v=%b cnt=%0d, want v=0 cnt=1", out_valid, issued_count);
      end
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_instr = 16'h3000 + 16'(k);
         step();
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_after4: got in_ready=%b, want 0", in_ready);
      end
      in_instr = 16'h3004;
      repeat (2) step();
      checks++;
      if (in_ready !== 1'b0 || opcode !== 4'h3 || operand !== 12'h000) begin
         errors++;
         $display("FAIL full_blocked: got r=%b op=%h opd=%h, want r=0 op=3 opd=000",
                  in_ready, opcode, operand);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || operand !== 12'h001) begin
         errors++;
         $display("FAIL full_pop: got r=%b opd=%h, want r=1 opd=001", in_ready, operand);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_fifth: got in_ready=%b, want 0", in_ready);
      end
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_drain: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_halt_stream();
      test_reset();
      out_ready = 1'b1;
      for (int op = 0; op < 16; op++) begin
         in_valid = 1'b1;
         in_instr = {4'(op), 12'h0A0 + 12'(op)};
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      checks++;
      if (halted !== 1'b1 || out_valid !== 1'b0 || issued_count !== 8'd16) begin
         errors++;
         $display("FAIL halt_stream: got h=%b v=%b cnt=%0d, want h=1 v=0 cnt=16",
                  halted, out_valid, issued_count);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_instr = 16'h4100 + 16'(k);
         step();
      end
      checks++;
      if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || issued_count !== 8'd16) begin
         errors++;
         $display("FAIL halt_accept: got h=%b v=%b r=%b cnt=%0d, want h=1 v=0 r=1 cnt=16",
                  halted, out_valid, in_ready, issued_count);
      end
      flush    = 1'b1;
      in_instr = 16'h7777;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || issued_count !== 8'd16) begin
         errors++;
         $display("FAIL flush: got h=%b v=%b r=%b cnt=%0d, want h=0 v=0 r=1 cnt=16",
                  halted, out_valid, in_ready, issued_count);
      end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 16'h5ABC;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || opcode !== 4'h5 || operand !== 12'hABC) begin
         errors++;
         $display("FAIL flush_run: got v=%b op=%h opd=%h, want v=1 op=5 opd=abc",
                  out_valid, opcode, operand);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      test_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_instr = {4'h2, 12'(i)};
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      out_ready = 1'b0;
      checks++;
      if (issued_count !== 8'd44) begin
         errors++;
         $display("FAIL count_wrap: got %0d, want 44", issued_count);
      end
   endtask

`ifdef OPCODE_ISSUE_STALL_COUNT_EN
   task automatic test_stall();
      test_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 16'h6001;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      checks++;
      if (stall_count !== 8'd10) begin
         errors++;
         $display("FAIL stall_mid: got %0d, want 10", stall_count);
      end
      repeat (250) step();
      checks++;
      if (stall_count !== 8'd255) begin
         errors++;
         $display("FAIL stall_sat: got %0d, want 255", stall_count);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (stall_count !== 8'd0) begin
         errors++;
         $display("FAIL stall_flush: got %0d, want 0", stall_count);
      end
   endtask
`endif

   task automatic test_reset_mid();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_instr = 16'h8100 + 16'(k);
         step();
      end
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_instr = 16'h9200 + 16'(k);
         step();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || halted !== 1'b0 ||
          opcode !== 4'h0 || operand !== 12'h0 || issued_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_async: got v=%b r=%b h=%b op=%h opd=%h cnt=%0d, want 0 1 0 0 000 0",
                  out_valid, in_ready, halted, opcode, operand, issued_count);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_instr = 16'hC123;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || opcode !== 4'hC || operand !== 12'h123) begin
         errors++;
         $display("FAIL reset_first: got v=%b op=%h opd=%h, want v=1 op=c opd=123",
                  out_valid, opcode, operand);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (issued_count !== 8'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_issue: got cnt=%0d v=%b, want cnt=1 v=0", issued_count, out_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b0;
      exp_count = 8'd0;
      exp_halt  = 1'b0;
      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none
      test_reset();
      test_single();
      test_full();
      test_halt_stream();
      test_flush();
      test_wrap();
`ifdef OPCODE_ISSUE_STALL_COUNT_EN
      test_stall();
`endif
      test_reset_mid();
      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/opcode_issue.md
OPCODE_ISSUE -- requirements
Module: opcode_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered instruction entries (power of two, 2..16).
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning the instruction word width; the opcode is always bits [INSTR_W-1:INSTR_W-4].
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous clear of buffer and state.
REQ-006 The block SHALL have port in_valid  input  1  upstream instruction present.
REQ-007 The block SHALL have port in_instr  input  INSTR_W  instruction word.
REQ-008 The block SHALL have port in_ready  output  1  buffer can accept.
REQ-009 The block SHALL have port out_valid  output  1  opcode/operand valid toward the ALU decoder.
REQ-010 The block SHALL have port out_ready  input  1  decoder side consumes.
REQ-011 The block SHALL have port opcode  output  4  head-entry opcode field, driving the aludec opcode input.
REQ-012 The block SHALL have port operand  output  INSTR_W-4  head-entry remaining bits.
REQ-013 The block SHALL have port halted  output  1  HALT state indicator.
REQ-014 The block SHALL have port issued_count  output  8  count of issued instructions.

Function
REQ-015 The block SHALL accept an instruction when in_valid and in_ready are both high at a rising edge, and issue one when out_valid and out_ready are both high.
REQ-016 The block SHALL drive in_ready = not full; there is no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-017 The block SHALL drive out_valid = not empty and state==RUN; opcode and operand SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 The block SHALL make an instruction accepted into an empty buffer at edge N visible on opcode/out_valid after edge N (one-cycle latency), with no combinational in-to-out path.
REQ-019 The block SHALL allow a simultaneous push and pop when neither full nor empty; occupancy is then unchanged.
REQ-020 The block SHALL have two states: RUN (reset state) and HALT.
REQ-021 The block SHALL transition RUN->HALT on the edge an instruction with opcode 4'b1111 is issued; that instruction is counted.
REQ-022 In HALT, the block SHALL hold out_valid low and keep accepting while not full; the only exit is flush (->RUN) or reset.
REQ-023 The block SHALL increment issued_count by 1 per issue, wrapping 255->0.
REQ-024 The block SHALL treat flush as highest priority: on flush it empties the buffer, enters RUN, ignores a same-cycle push/pop, and leaves issued_count unchanged.
REQ-025 The block SHALL wrap read and write pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-026 On rst_n low, the block SHALL immediately and asynchronously force: buffer empty, state RUN, in_ready=1, out_valid=0, halted=0, opcode=0, operand=0, issued_count=0.
REQ-027 The block SHALL discard buffered entries when reset is asserted mid-operation; the first accept after rst_n rises is the next issued entry.

Configuration
REQ-028 With macro OPCODE_ISSUE_STALL_COUNT_EN defined, the block SHALL add output stall_count (8 bits, reset 0), which increments each cycle out_valid=1 and out_ready=0, saturates at 255, and clears on flush.
REQ-029 Without OPCODE_ISSUE_STALL_COUNT_EN, the block SHALL have neither the stall_count port nor its logic; all other behaviour is identical.

Verification
REQ-030 The bench SHALL cover: push 0x1234 into empty buffer with out_ready=0 -> next cycle out_valid=1, opcode=4'h1, operand=12'h234, held stable.
REQ-031 The bench SHALL cover: push 5 words with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th accept; the 5th is not accepted until one pop.
REQ-032 The bench SHALL cover: stream opcodes 0..15 with out_ready=1 -> issue order 0..15, HALT entered after 0xF issues, halted=1, out_valid=0, issued_count=16.
REQ-033 The bench SHALL cover: flush with 3 entries in HALT and push asserted -> next cycle empty, RUN, in_ready=1, issued_count unchanged.
REQ-034 The bench SHALL cover: 300 issues -> issued_count=44 (wrap); with the macro and 260 stall cycles -> stall_count=255.
REQ-035 The bench SHALL cover: rst_n low mid-stream between edges -> outputs reach reset values before the next edge.
